sram_mem_ctrl: RTL
==================

Name: sram_mem_ctrl

Overview:
- Multi-cycle controller placed at the MEM stage, between the pipeline's memory request and an external 16-bit asynchronous SRAM.
- Converts each 32-bit load or store into two half-word SRAM accesses.
- Drops `ready` so the hazard/freeze logic stalls all pipeline registers until the access completes.
- Delivers load data to the MEM/WB register.

Parameters:
- BASE_ADDR, 1024: byte address mapped to SRAM word 0.
- WAIT_CYCLES, 1: extra cycles per half-word phase. Legal range is 1..7.
- SRAM_AW, 18: SRAM half-word address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  store request, held stable while ready=0.
- rd_en  in  1  load request, held stable while ready=0.
- address  in  32  byte address, the ALU result.
- write_data  in  32  store data, the Rm value.
- read_data  out  32  load result; valid when ready=1 in DONE after a read.
- ready  out  1  0 means freeze the pipeline.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_o  out  16  write data to the pad.
- sram_dq_i  in  16  read data from the pad.
- sram_dq_oe  out  1  1 means the controller drives the DQ pad.
- sram_we_n  out  1  active-low write strobe.
- sram_oe_n  out  1  active-low output enable.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, phase counter=0.
  - read_data=0, sram_addr=0, sram_dq_o=0, sram_dq_oe=0.
  - sram_we_n=1, sram_oe_n=1.
  - ready follows its combinational equation, so it is 1 with no request.
  - Reset mid-transaction aborts immediately with no partial-write cleanup; the pipeline re-executes the access.
- Address map:
  - word = (address - BASE_ADDR) >> 2, 32-bit subtract.
  - Low half-word: sram_addr = {word[SRAM_AW-2:0], 1'b0}.
  - High half-word: sram_addr = {word[SRAM_AW-2:0], 1'b1}.
  - Upper bits are discarded, so accesses wrap modulo SRAM size.
  - Unaligned byte offsets address[1:0] are ignored.
  - No range check.
- Request:
  - req = wr_en | rd_en.
  - wr_en and rd_en both high is illegal; it is treated as a write.
- ready = ~req | (state==DONE). This is combinational.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE, req=1: latch kind (write/read), register sram_addr to the low half, go to LO with counter=0.
  - LO: stay WAIT_CYCLES+1 cycles, then go to HI. The address is updated to the high half on that transition.
  - HI: stay WAIT_CYCLES+1 cycles, then go to DONE.
  - DONE: ready=1 for exactly one cycle, then IDLE unconditionally. The pipeline advances on this edge.
- Write phase (LO or HI):
  - sram_dq_oe=1.
  - sram_dq_o = write_data[15:0] in LO, write_data[31:16] in HI.
  - sram_we_n=0 for all phase cycles except the last. It returns to 1 on the last cycle, with address and data held.
- Read phase:
  - sram_oe_n=0 and sram_dq_oe=0 throughout.
  - sram_dq_i is sampled on the last cycle of the phase: into the lo register in LO, into read_data[31:16] in HI.
  - read_data[15:0] is loaded from the lo register at the same edge as the HI sample.
- read_data holds its value until the next read completes; stores do not change it.
- Latency, WAIT_CYCLES=1: request visible in cycle 0, LO in cycles 1–2, HI in cycles 3–4, DONE in cycle 5 (ready=1). Total: 6 cycles per access, 5 of them stalled.
- Outside LO/HI, all SRAM controls are registered and inactive: we_n=1, oe_n=1, dq_oe=0.
- If req drops mid-transaction (protocol violation), the access still completes through DONE.
- A new request in the cycle after DONE starts a fresh transaction from IDLE. There is no back-to-back bypass.

Decomposition:
- Package mem_pkg:
  - state enum sram_state_t {IDLE, LO, HI, DONE}.
  - BASE_ADDR and SRAM_AW defaults.
  - Phase-counter width constant.
- One natural sub-module: sram_addr_map. It is combinational and maps address plus half-select to sram_addr. It is reused by the future cache fill path.

Test Plan:
- Store address=1024, data=0xDEADBEEF:
  - sram_addr=0 with dq_o=0xBEEF, we_n low in cycle 1 only.
  - sram_addr=1 with dq_o=0xDEAD, we_n low in cycle 3 only.
  - ready=1 in cycle 5 only.
- Load address=1028, SRAM model holding half-words 2=0x5678 and 3=0x1234:
  - read_data=0x12345678 in cycle 5, ready=0 in cycles 0–4.
  - oe_n=0 and dq_oe=0 in cycles 1–4.
- WAIT_CYCLES=3, load: ready rises in cycle 9; each phase lasts 4 cycles.
- rst_n pulsed low in cycle 3 of a store: outputs return to reset values asynchronously, and state is IDLE on release.
- Back-to-back load then store to address 1032: second access starts in the cycle after DONE; read_data unchanged by the store.
- wr_en=rd_en=1, address=1024: behaves as a write (dq_oe=1, oe_n stays 1).

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller and its address map.
package mem_pkg;

    localparam int unsigned DEF_BASE_ADDR = 1024;
    localparam int unsigned DEF_SRAM_AW   = 18;
    // Wide enough for a phase of up to eight cycles (WAIT_CYCLES 1..7).
    localparam int unsigned PH_CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } sram_state_t;

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// Pipeline-side memory request bus between the MEM stage and the SRAM controller.
interface sram_mem_ctrl_if;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );

endinterface

// File: rtl/sram_mem_ctrl_addr_map.sv
// Byte address to SRAM half-word address; shared with the cache fill path.
module sram_addr_map
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'(DEF_BASE_ADDR),
    parameter int unsigned SRAM_AW   = DEF_SRAM_AW
) (
    input  logic [31:0]        address,
    input  logic               half,
    output logic [SRAM_AW-1:0] sram_addr
);

    logic [31:0] offset;
    logic        unused_offset_bits;

    // Word index is offset[31:2]; bits above the SRAM size wrap away.
    always_comb begin
        offset    = address - BASE_ADDR;
        sram_addr = {offset[SRAM_AW:2], half};
    end

    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage controller: splits each 32-bit load/store into two 16-bit async SRAM
// accesses, holding ready low so the pipeline freezes until the access completes.
module sram_mem_ctrl
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'(DEF_BASE_ADDR),
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    sram_mem_ctrl_if.slave     bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_o,
    input  logic [15:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam logic [PH_CNT_W-1:0] LAST = PH_CNT_W'(WAIT_CYCLES);

    sram_state_t         state, nxt_state;
    logic [PH_CNT_W-1:0] cnt, nxt_cnt;
    logic                is_wr, nxt_wr;
    logic                req, phase_last;
    logic [15:0]         lo_q;
    logic [SRAM_AW-1:0]  map_addr, addr_d;
    logic [15:0]         dq_o_d;
    logic                dq_oe_d, we_n_d, oe_n_d;

    assign req       = bus.wr_en | bus.rd_en;
    assign bus.ready = ~req | (state == DONE);

    sram_addr_map #(
        .BASE_ADDR (BASE_ADDR),
        .SRAM_AW   (SRAM_AW)
    ) u_addr_map (
        .address   (bus.address),
        .half      (nxt_state == HI),
        .sram_addr (map_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            is_wr         <= 1'b0;
            lo_q          <= '0;
            bus.read_data <= '0;
            sram_addr     <= '0;
            sram_dq_o     <= '0;
            sram_dq_oe    <= 1'b0;
            sram_we_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            is_wr      <= nxt_wr;
            sram_addr  <= addr_d;
            sram_dq_o  <= dq_o_d;
            sram_dq_oe <= dq_oe_d;
            sram_we_n  <= we_n_d;
            sram_oe_n  <= oe_n_d;
            if (!is_wr && phase_last) begin
                if (state == LO) lo_q <= sram_dq_i;
                if (state == HI) bus.read_data <= {sram_dq_i, lo_q};
            end
        end
    end

    always_comb begin
        nxt_state  = state;
        nxt_cnt    = '0;
        nxt_wr     = is_wr;
        phase_last = (cnt == LAST);
        case (state)
            IDLE: if (req) begin
                nxt_state = LO;
                nxt_wr    = bus.wr_en;
            end
            LO:   if (phase_last) nxt_state = HI;
                  else            nxt_cnt   = cnt + 1'b1;
            HI:   if (phase_last) nxt_state = DONE;
                  else            nxt_cnt   = cnt + 1'b1;
            DONE: nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Pad controls are registered, so they are derived from the upcoming state and count.
    always_comb begin
        addr_d  = sram_addr;
        dq_o_d  = '0;
        dq_oe_d = 1'b0;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        if (nxt_state == LO || nxt_state == HI) begin
            if (nxt_state != state) addr_d = map_addr;
            if (nxt_wr) begin
                dq_oe_d = 1'b1;
                we_n_d  = (nxt_cnt == LAST);
                dq_o_d  = (nxt_state == HI) ? bus.write_data[31:16] : bus.write_data[15:0];
            end else begin
                oe_n_d  = 1'b0;
            end
        end
    end

endmodule
